// File: rtl/psum_accum_writeback_if.sv
// Handshake/bus bundle for psum_accum_writeback: config, psum stream, BRAM ports, status.
// The slave side is the accumulator; the master side is the core/BRAM/register environment.
interface psum_accum_writeback_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int REG_WIDTH  = 32
);
    logic [REG_WIDTH-1:0]  i_conf_ctrl;
    logic [REG_WIDTH-1:0]  i_conf_outputsize;
    logic [REG_WIDTH-1:0]  i_conf_numpass;
    logic [DATA_WIDTH-1:0] i_psum_data;
    logic                  i_psum_valid;
    logic                  o_psum_ready;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdat;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic [NUM_BYTE-1:0]   mem_wren;
    logic                  mem_enb;
    logic [REG_WIDTH-1:0]  o_conf_status;

    modport slave (
        input  i_conf_ctrl, i_conf_outputsize, i_conf_numpass,
        input  i_psum_data, i_psum_valid, mem_rdat,
        output o_psum_ready, mem_raddr, mem_waddr, mem_wdat, mem_wren, mem_enb, o_conf_status
    );

    modport master (
        output i_conf_ctrl, i_conf_outputsize, i_conf_numpass,
        output i_psum_data, i_psum_valid, mem_rdat,
        input  o_psum_ready, mem_raddr, mem_waddr, mem_wdat, mem_wren, mem_enb, o_conf_status
    );
endinterface

// File: rtl/psum_accum_writeback.sv
// Read-modify-write psum accumulator: read at accept, write one cycle later, forwarding on same-address hazards.
// Optional macro PSUM_SATURATE_EN clamps overflowing sums instead of wrapping.
module psum_accum_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    psum_accum_writeback_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [REG_WIDTH-1:0]  cnt_q, cnt_d;
    logic [REG_WIDTH-1:0]  pass_q, pass_d;
    logic [REG_WIDTH-1:0]  osize_q, osize_d;
    logic [REG_WIDTH-1:0]  lastpass_q, lastpass_d;
    logic                  ovf_q, ovf_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_first_q, s1_first_d;
    logic                  s1_fwd_q, s1_fwd_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_psum_q, s1_psum_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;

    logic                  accept;
    logic                  cnt_wrap;
    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH-1:0] sum_wrap;
    logic [DATA_WIDTH-1:0] sum_res;
    logic [DATA_WIDTH-1:0] wdat_c;
    logic                  ovf_now;
    logic                  ctrl_unused;

    assign ctrl_unused = ^bus.i_conf_ctrl[REG_WIDTH-1:1];

    assign accept   = (state_q == RUN) && bus.i_psum_valid;
    assign cnt_wrap = (cnt_q == osize_q);

    // The previous write lands on the same edge as this read, so the BRAM
    // returns stale data for a back-to-back same address; use the held write data instead.
    always_comb begin
        addend   = s1_fwd_q ? wdat_q : bus.mem_rdat;
        sum_wrap = s1_psum_q + addend;
        ovf_now  = s1_vld_q && !s1_first_q &&
                   (s1_psum_q[DATA_WIDTH-1] == addend[DATA_WIDTH-1]) &&
                   (sum_wrap[DATA_WIDTH-1] != s1_psum_q[DATA_WIDTH-1]);
`ifdef PSUM_SATURATE_EN
        if (ovf_now)
            sum_res = s1_psum_q[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            sum_res = sum_wrap;
`else
        sum_res = sum_wrap;
`endif
        if (!s1_vld_q)       wdat_c = '0;
        else if (s1_first_q) wdat_c = s1_psum_q;
        else                 wdat_c = sum_res;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        osize_d    = osize_q;
        lastpass_d = lastpass_q;
        ovf_d      = ovf_q | ovf_now;
        s1_vld_d   = accept;
        s1_first_d = s1_first_q;
        s1_fwd_d   = s1_fwd_q;
        s1_addr_d  = s1_addr_q;
        s1_psum_d  = s1_psum_q;
        wdat_d     = s1_vld_q ? wdat_c : wdat_q;

        if (accept) begin
            s1_addr_d  = ADDR_WIDTH'(cnt_q);
            s1_psum_d  = bus.i_psum_data;
            s1_first_d = (pass_q == '0);
            s1_fwd_d   = s1_vld_q && (s1_addr_q == ADDR_WIDTH'(cnt_q));
            if (cnt_wrap) begin
                cnt_d  = '0;
                pass_d = pass_q + 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: if (bus.i_conf_ctrl[0]) begin
                state_d    = RUN;
                cnt_d      = '0;
                pass_d     = '0;
                osize_d    = bus.i_conf_outputsize;
                lastpass_d = (bus.i_conf_numpass == '0) ? '0 : bus.i_conf_numpass - 1'b1;
                ovf_d      = 1'b0;
            end
            RUN: begin
                if (!bus.i_conf_ctrl[0])
                    state_d = IDLE;
                else if (accept && cnt_wrap && (pass_q == lastpass_q))
                    state_d = DONE;
            end
            DONE: if (!bus.i_conf_ctrl[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pass_q     <= '0;
            osize_q    <= '0;
            lastpass_q <= '0;
            ovf_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_fwd_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_psum_q  <= '0;
            wdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            osize_q    <= osize_d;
            lastpass_q <= lastpass_d;
            ovf_q      <= ovf_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_fwd_q   <= s1_fwd_d;
            s1_addr_q  <= s1_addr_d;
            s1_psum_q  <= s1_psum_d;
            wdat_q     <= wdat_d;
        end
    end

    assign bus.o_psum_ready  = (state_q == RUN);
    assign bus.mem_raddr     = accept ? ADDR_WIDTH'(cnt_q) : '0;
    assign bus.mem_waddr     = s1_vld_q ? s1_addr_q : '0;
    assign bus.mem_wdat      = wdat_c;
    assign bus.mem_wren      = {NUM_BYTE{s1_vld_q}};
    assign bus.mem_enb       = (state_q == RUN) || s1_vld_q;
    assign bus.o_conf_status = {{(REG_WIDTH-3){1'b0}}, ovf_q, state_q == DONE, state_q == RUN};
endmodule

// File: tb/tb_psum_accum_writeback.sv
// Table-driven bench for psum_accum_writeback with a 1-cycle-latency BRAM model.
module tb_psum_accum_writeback;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    psum_accum_writeback_if bus ();
    psum_accum_writeback dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] bram [0:15];
    always @(posedge clk) begin
        if (bus.mem_wren == 4'hF) bram[bus.mem_waddr[3:0]] <= bus.mem_wdat;
        bus.mem_rdat <= bram[bus.mem_raddr[3:0]];
    end

`ifdef PSUM_SATURATE_EN
    localparam logic [31:0] OVF_W = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_W = 32'h8000_0000;
`endif

    typedef struct {
        string       nm;
        logic [31:0] os, np;
        logic        c, v;
        logic [31:0] p;
        logic        rdy;
        logic [31:0] ra;
        logic        en, wen;
        logic [31:0] wa, wd;
        logic [2:0]  st;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] cfg_os, cfg_np;
    int          total = 0;
    int          bad   = 0;

    task automatic add(input string nm, input logic c, input logic v, input logic [31:0] p,
                       input logic rdy, input logic [31:0] ra, input logic en, input logic wen,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [2:0] st);
        vec_t r;
        r.nm = nm; r.os = cfg_os; r.np = cfg_np; r.c = c; r.v = v; r.p = p;
        r.rdy = rdy; r.ra = ra; r.en = en; r.wen = wen; r.wa = wa; r.wd = wd; r.st = st;
        vecs.push_back(r);
    endtask

    task automatic check_vec(input vec_t r);
        logic ok;
        ok = (bus.o_psum_ready == r.rdy) && (bus.mem_enb == r.en) &&
             (bus.mem_wren == (r.wen ? 4'hF : 4'h0)) &&
             (bus.o_conf_status == {29'b0, r.st});
        if (r.rdy && r.v) ok = ok && (bus.mem_raddr == r.ra);
        if (r.wen)        ok = ok && (bus.mem_waddr == r.wa) && (bus.mem_wdat == r.wd);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got rdy=%0b ra=%0h en=%0b wren=%0h wa=%0h wd=%0h st=%0h; want rdy=%0b ra=%0h en=%0b wen=%0b wa=%0h wd=%0h st=%0h",
                     r.nm, bus.o_psum_ready, bus.mem_raddr, bus.mem_enb, bus.mem_wren, bus.mem_waddr,
                     bus.mem_wdat, bus.o_conf_status, r.rdy, r.ra, r.en, r.wen, r.wa, r.wd, r.st);
        end
    endtask

    task automatic check_zero(input string nm);
        total++;
        if (bus.o_psum_ready !== 1'b0 || bus.mem_raddr !== 32'h0 || bus.mem_waddr !== 32'h0 ||
            bus.mem_wdat !== 32'h0 || bus.mem_wren !== 4'h0 || bus.mem_enb !== 1'b0 ||
            bus.o_conf_status !== 32'h0) begin
            bad++;
            $display("FAIL %s: got rdy=%0b ra=%0h wa=%0h wd=%0h wren=%0h en=%0b st=%0h; want all zero",
                     nm, bus.o_psum_ready, bus.mem_raddr, bus.mem_waddr, bus.mem_wdat,
                     bus.mem_wren, bus.mem_enb, bus.o_conf_status);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bram[i] = 32'h0;
        bus.mem_rdat = '0;
        bus.i_conf_ctrl = '0; bus.i_conf_outputsize = '0; bus.i_conf_numpass = '0;
        bus.i_psum_valid = 1'b0; bus.i_psum_data = '0;

        // outputsize=3, numpass=1: plain overwrite
        cfg_os = 3; cfg_np = 1;
        add("s1_start", 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        add("s1_a0",    1, 1, 1, 1, 0, 1, 0, 0, 0, 3'b001);
        add("s1_a1",    1, 1, 2, 1, 1, 1, 1, 0, 1, 3'b001);
        add("s1_a2",    1, 1, 3, 1, 2, 1, 1, 1, 2, 3'b001);
        add("s1_a3",    1, 1, 4, 1, 3, 1, 1, 2, 3, 3'b001);
        add("s1_wlast", 1, 0, 0, 0, 0, 1, 1, 3, 4, 3'b010);
        add("s1_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010);
        add("s1_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        // outputsize=1, numpass=2: accumulate via BRAM read
        cfg_os = 1; cfg_np = 2;
        add("s2_start", 1, 0, 0,  0, 0, 0, 0, 0, 0,  3'b000);
        add("s2_a0",    1, 1, 5,  1, 0, 1, 0, 0, 0,  3'b001);
        add("s2_a1",    1, 1, 7,  1, 1, 1, 1, 0, 5,  3'b001);
        add("s2_a2",    1, 1, 10, 1, 0, 1, 1, 1, 7,  3'b001);
        add("s2_a3",    1, 1, 20, 1, 1, 1, 1, 0, 15, 3'b001);
        add("s2_wlast", 1, 0, 0,  0, 0, 1, 1, 1, 27, 3'b010);
        add("s2_done",  0, 0, 0,  0, 0, 0, 0, 0, 0,  3'b010);
        add("s2_idle",  0, 0, 0,  0, 0, 0, 0, 0, 0,  3'b000);
        // outputsize=0, numpass=4: every access is a forward hazard
        cfg_os = 0; cfg_np = 4;
        add("s3_start", 1, 0, 0, 0, 0, 0, 0, 0, 0,  3'b000);
        add("s3_a0",    1, 1, 3, 1, 0, 1, 0, 0, 0,  3'b001);
        add("s3_a1",    1, 1, 3, 1, 0, 1, 1, 0, 3,  3'b001);
        add("s3_a2",    1, 1, 3, 1, 0, 1, 1, 0, 6,  3'b001);
        add("s3_a3",    1, 1, 3, 1, 0, 1, 1, 0, 9,  3'b001);
        add("s3_wlast", 1, 0, 0, 0, 0, 1, 1, 0, 12, 3'b010);
        add("s3_done",  0, 0, 0, 0, 0, 0, 0, 0, 0,  3'b010);
        add("s3_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0,  3'b000);
        // signed overflow on a forwarded add
        cfg_os = 0; cfg_np = 2;
        add("s4_start", 1, 0, 0,            0, 0, 0, 0, 0, 0,            3'b000);
        add("s4_a0",    1, 1, 32'h7FFFFFFF, 1, 0, 1, 0, 0, 0,            3'b001);
        add("s4_a1",    1, 1, 1,            1, 0, 1, 1, 0, 32'h7FFFFFFF, 3'b001);
        add("s4_wovf",  1, 0, 0,            0, 0, 1, 1, 0, OVF_W,        3'b010);
        add("s4_done",  0, 0, 0,            0, 0, 0, 0, 0, 0,            3'b110);
        add("s4_idle",  0, 0, 0,            0, 0, 0, 0, 0, 0,            3'b100);
        // enable dropped after 2 of 4 accepts, then clean restart
        cfg_os = 3; cfg_np = 1;
        add("s5_start", 1, 0, 0,  0, 0, 0, 0, 0, 0,  3'b100);
        add("s5_a0",    1, 1, 11, 1, 0, 1, 0, 0, 0,  3'b001);
        add("s5_a1",    1, 1, 12, 1, 1, 1, 1, 0, 11, 3'b001);
        add("s5_drop",  0, 0, 0,  1, 0, 1, 1, 1, 12, 3'b001);
        add("s5_idle",  0, 0, 0,  0, 0, 0, 0, 0, 0,  3'b000);
        add("s5_rst",   1, 0, 0,  0, 0, 0, 0, 0, 0,  3'b000);
        add("s5_r0",    1, 1, 9,  1, 0, 1, 0, 0, 0,  3'b001);
        add("s5_r1",    1, 1, 8,  1, 1, 1, 1, 0, 9,  3'b001);
        add("s5_r2",    1, 1, 7,  1, 2, 1, 1, 1, 8,  3'b001);
        add("s5_r3",    1, 1, 6,  1, 3, 1, 1, 2, 7,  3'b001);
        add("s5_rlast", 1, 0, 0,  0, 0, 1, 1, 3, 6,  3'b010);
        add("s5_rdone", 0, 0, 0,  0, 0, 0, 0, 0, 0,  3'b010);
        add("s5_ridle", 0, 0, 0,  0, 0, 0, 0, 0, 0,  3'b000);
        // numpass=0 behaves as a single pass
        cfg_os = 0; cfg_np = 0;
        add("s6_start", 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        add("s6_a0",    1, 1, 5, 1, 0, 1, 0, 0, 0, 3'b001);
        add("s6_wlast", 1, 0, 0, 0, 0, 1, 1, 0, 5, 3'b010);
        add("s6_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010);
        add("s6_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        repeat (2) @(negedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk) rst = 1'b1;
        #1 check_zero("reset_release");

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.i_conf_ctrl       = {31'b0, vecs[i].c};
            bus.i_conf_outputsize = vecs[i].os;
            bus.i_conf_numpass    = vecs[i].np;
            bus.i_psum_valid      = vecs[i].v;
            bus.i_psum_data       = vecs[i].p;
            #1 check_vec(vecs[i]);
        end

        // reset asserted mid-RUN with a write in flight
        @(negedge clk);
        bus.i_conf_ctrl = 32'h1; bus.i_conf_outputsize = 3; bus.i_conf_numpass = 1;
        bus.i_psum_valid = 1'b0;
        @(negedge clk);
        bus.i_psum_valid = 1'b1; bus.i_psum_data = 32'd1;
        @(negedge clk);
        bus.i_psum_data = 32'd2;
        #1;
        total++;
        if (bus.mem_wren !== 4'hF || bus.mem_enb !== 1'b1) begin
            bad++;
            $display("FAIL midrun_pre: got wren=%0h en=%0b; want wren=f en=1", bus.mem_wren, bus.mem_enb);
        end
        rst = 1'b0;
        bus.i_psum_valid = 1'b0; bus.i_conf_ctrl = 32'h0;
        #1 check_zero("midrun_reset");
        @(negedge clk) rst = 1'b1;
        #1 check_zero("after_reset_idle");
        @(negedge clk);
        #1 check_zero("after_reset_idle2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
